aud_dsp_var: RTL and testbench

- Parametrised, single-clock successor of the lab-3 playback DSP: generates SRAM read addresses and DAC sample values for normal, fast (skip), slow-hold and slow-linear playback, forward or reverse.
- Sits between the SRAM controller (read handshake) and the I2S player.
- Runs entirely on i_clk; i_daclrck is treated as a data input whose rising edge marks one output sample period.
- Playback ends at a programmable recorded length, not at the full address space.

---
 rtl/aud_dsp_var.sv | 261 ++++++++++++++++++++++++++
 tb/tb_aud_dsp_var.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_dsp_var.sv
// Playback DSP: turns SRAM reads into DAC samples for normal, skip, hold and linear-interpolated playback, forward or reverse.
// Latency: a daclrck rising edge raises the internal tick 3 clocks later; o_dac_data changes 1 clock after the tick.
// Backpressure: the SRAM read is held until i_sram_valid; a tick that lands while a read is outstanding is reported as underrun.
module aud_dsp_var #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20,
    parameter int SPD_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [1:0]        i_mode,
    input  logic [SPD_W-1:0]  i_speed,
    input  logic              i_reverse,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic              i_daclrck,
    output logic              o_sram_req,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic              i_sram_valid,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_underrun
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_PAUSE} state_t;

    // Interpolation sum is wide enough for prev + (2^SPD_W-1)*step without overflow.
    localparam int PW = DATA_W + SPD_W + 2;
    localparam logic signed [PW-1:0] SMAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [SPD_W-1:0]    n_q, n_d;
    logic                rev_q, rev_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [ADDR_W-1:0]   pos_q, pos_d;
    logic [SPD_W-1:0]    j_q, j_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [DATA_W-1:0]   cur_q, cur_d;
    logic [DATA_W:0]     step_q, step_d;
    logic                first_q, first_d;
    logic                pend_q, pend_d;
    logic                fin_q, fin_d;
    logic [DATA_W-1:0]   dac_q, dac_d;
    logic                done_q, done_d;
    logic                urun_q, urun_d;
    logic                s1_q, s2_q, s3_q, tick_q;

    logic [ADDR_W:0]          adv_w, pos_fwd_w;
    logic                     end_hit_w;
    logic [ADDR_W-1:0]        pos_adv_w;
    logic                     last_j_w;
    logic signed [PW-1:0]     lin_w;
    logic [DATA_W-1:0]        lin_sat_w;
    logic [DATA_W-1:0]        samp_w;
    logic [DATA_W-1:0]        prev_new_w;
    logic signed [DATA_W:0]   diff_w, n_s_w, step_new_w;
    logic                     pend_v;

    // Fast mode strides by N; hold and linear modes step one word at a time.
    assign adv_w     = (mode_q == 2'd0) ? {{(ADDR_W+1-SPD_W){1'b0}}, n_q} : (ADDR_W+1)'(1);
    assign pos_fwd_w = {1'b0, pos_q} + adv_w;
    assign end_hit_w = rev_q ? ({1'b0, pos_q} < adv_w) : (pos_fwd_w > {1'b0, end_q});
    assign pos_adv_w = rev_q ? (pos_q - adv_w[ADDR_W-1:0]) : pos_fwd_w[ADDR_W-1:0];
    assign last_j_w  = (j_q == (n_q - SPD_W'(1)));

    // Linear interpolation point prev + j*step.
    assign lin_w = $signed({{(PW-DATA_W){prev_q[DATA_W-1]}}, prev_q})
                 + ($signed({{(PW-SPD_W){1'b0}}, j_q})
                    * $signed({{(PW-DATA_W-1){step_q[DATA_W]}}, step_q}));

    // Clamp the interpolated value into the signed sample range.
    always_comb begin
        lin_sat_w = lin_w[DATA_W-1:0];
        if (lin_w > SMAX) begin
            lin_sat_w = SMAX[DATA_W-1:0];
        end else if (lin_w < SMIN) begin
            lin_sat_w = SMIN[DATA_W-1:0];
        end
    end

    assign samp_w = (mode_q == 2'd2) ? lin_sat_w : cur_q;

    // Step for the segment being fetched; the first fetch has prev == cur so the step is 0.
    assign prev_new_w = first_q ? i_sram_data : cur_q;
    assign diff_w     = $signed({i_sram_data[DATA_W-1], i_sram_data})
                      - $signed({prev_new_w[DATA_W-1], prev_new_w});
    assign n_s_w      = $signed({{(DATA_W+1-SPD_W){1'b0}}, n_q});
    assign step_new_w = diff_w / n_s_w;

    // Synchronise the LR clock and turn its rising edge into a one-cycle tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            s1_q   <= i_daclrck;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            tick_q <= s2_q & ~s3_q;
        end
    end

    // Next-state and datapath updates; stop beats pause beats tick.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        rev_d   = rev_q;
        end_d   = end_q;
        pos_d   = pos_q;
        j_d     = j_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        step_d  = step_q;
        first_d = first_q;
        pend_d  = pend_q;
        fin_d   = fin_q;
        dac_d   = dac_q;
        done_d  = 1'b0;
        urun_d  = 1'b0;
        pend_v  = pend_q ^ i_pause;
        case (state_q)
            S_IDLE: begin
                dac_d = '0;
                if (i_start) begin
                    mode_d  = (i_mode == 2'd3) ? 2'd0 : i_mode;
                    n_d     = (i_speed == '0) ? SPD_W'(1) : i_speed;
                    rev_d   = i_reverse;
                    end_d   = i_end_addr;
                    pos_d   = i_reverse ? i_end_addr : '0;
                    j_d     = '0;
                    first_d = 1'b1;
                    pend_d  = 1'b0;
                    fin_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_stop) begin
                    dac_d   = '0;
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (tick_q) begin
                        urun_d = 1'b1;
                    end
                    if (i_sram_valid) begin
                        prev_d  = prev_new_w;
                        cur_d   = i_sram_data;
                        step_d  = step_new_w;
                        first_d = 1'b0;
                        pend_d  = 1'b0;
                        if (pend_v) begin
                            dac_d   = '0;
                            state_d = S_PAUSE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        pend_d = pend_v;
                    end
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    dac_d   = '0;
                    fin_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (fin_q) begin
                    done_d  = 1'b1;
                    dac_d   = '0;
                    fin_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    dac_d   = '0;
                    state_d = S_PAUSE;
                end else if (tick_q) begin
                    dac_d = samp_w;
                    if (mode_q == 2'd0 || last_j_w) begin
                        j_d = '0;
                        if (end_hit_w) begin
                            fin_d = 1'b1;
                        end else begin
                            pos_d   = pos_adv_w;
                            state_d = S_FETCH;
                        end
                    end else begin
                        j_d = j_q + SPD_W'(1);
                    end
                end
            end
            S_PAUSE: begin
                dac_d = '0;
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                dac_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            n_q     <= '0;
            rev_q   <= 1'b0;
            end_q   <= '0;
            pos_q   <= '0;
            j_q     <= '0;
            prev_q  <= '0;
            cur_q   <= '0;
            step_q  <= '0;
            first_q <= 1'b0;
            pend_q  <= 1'b0;
            fin_q   <= 1'b0;
            dac_q   <= '0;
            done_q  <= 1'b0;
            urun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            n_q     <= n_d;
            rev_q   <= rev_d;
            end_q   <= end_d;
            pos_q   <= pos_d;
            j_q     <= j_d;
            prev_q  <= prev_d;
            cur_q   <= cur_d;
            step_q  <= step_d;
            first_q <= first_d;
            pend_q  <= pend_d;
            fin_q   <= fin_d;
            dac_q   <= dac_d;
            done_q  <= done_d;
            urun_q  <= urun_d;
        end
    end

    assign o_sram_req  = (state_q == S_FETCH);
    assign o_sram_addr = pos_q;
    assign o_dac_data  = dac_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_underrun  = urun_q;

endmodule

// File: tb/tb_aud_dsp_var.sv
// Bench for aud_dsp_var: directed and randomised playback runs against a sample-list reference model.
// Latency: samples o_dac_data 4 clocks after each daclrck rising edge.
// Backpressure: SRAM responder with programmable latency.
module tb_aud_dsp_var;

    logic        clk = 1'b0;
    logic        rst, start, pause, stop, rev, daclrck;
    logic [1:0]  mode;
    logic [3:0]  speed;
    logic [19:0] end_addr;
    logic        sram_req, sram_valid;
    logic [19:0] sram_addr;
    logic [15:0] sram_data, dac;
    logic        busy, done, underrun;

    aud_dsp_var #(.DATA_W(16), .ADDR_W(20), .SPD_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_mode(mode), .i_speed(speed), .i_reverse(rev), .i_end_addr(end_addr),
        .i_daclrck(daclrck), .o_sram_req(sram_req), .o_sram_addr(sram_addr),
        .i_sram_valid(sram_valid), .i_sram_data(sram_data), .o_dac_data(dac),
        .o_busy(busy), .o_done(done), .o_underrun(underrun)
    );

    always #5 clk = ~clk;

    logic signed [15:0] mem [0:15];
    int lat = 2;
    int addr_q[$];
    int exp_addr[$];
    int exp_smp[$];
    int done_cnt = 0;
    int urun_cnt = 0;
    int n_chk = 0, n_pass = 0, n_fail = 0;

    // SRAM model: answers each request after lat clocks and logs the address.
    initial begin
        logic [19:0] a;
        sram_valid = 1'b0;
        sram_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (sram_req) begin
                a = sram_addr;
                addr_q.push_back(int'(a));
                repeat (lat) @(posedge clk);
                #1 sram_valid = 1'b1;
                sram_data = mem[a[3:0]];
                @(posedge clk); #1 sram_valid = 1'b0;
            end
        end
    end

    // Pulse counters.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (underrun) urun_cnt <= urun_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: list of addresses read and samples heard, straight from the playback rules.
    task automatic build_model(input int md, input int n, input int rv, input int ea);
        int m, nn, stride, cur, prv, stp, v;
        m  = (md == 3) ? 0 : md;
        nn = (n == 0) ? 1 : n;
        stride = (m == 0) ? nn : 1;
        exp_addr.delete();
        exp_smp.delete();
        if (rv == 0) for (int a = 0; a <= ea; a += stride) exp_addr.push_back(a);
        else         for (int a = ea; a >= 0; a -= stride) exp_addr.push_back(a);
        for (int k = 0; k < exp_addr.size(); k++) begin
            cur = int'(mem[exp_addr[k]]);
            prv = (k == 0) ? cur : int'(mem[exp_addr[k-1]]);
            if (m == 0) exp_smp.push_back(cur);
            else if (m == 1) for (int j = 0; j < nn; j++) exp_smp.push_back(cur);
            else begin
                stp = (cur - prv) / nn;
                for (int j = 0; j < nn; j++) begin
                    v = prv + j * stp;
                    if (v > 32767) v = 32767;
                    if (v < -32768) v = -32768;
                    exp_smp.push_back(v);
                end
            end
        end
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_pause;
        @(negedge clk) pause = 1'b1;
        @(negedge clk) pause = 1'b0;
    endtask

    task automatic pulse_stop;
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    // One LR period; v is the DAC value one clock after the internal tick.
    task automatic tick(input int period, output int v);
        @(negedge clk) daclrck = 1'b1;
        repeat (4) @(posedge clk);
        #1 v = int'($signed(dac));
        repeat (period / 2 - 4) @(posedge clk);
        @(negedge clk) daclrck = 1'b0;
        repeat (period / 2) @(posedge clk);
    endtask

    task automatic setup(input int md, input int n, input int rv, input int ea);
        @(negedge clk);
        mode = 2'(md); speed = 4'(n); rev = rv[0]; end_addr = 20'(ea);
        build_model(md, n, rv, ea);
        addr_q.delete();
        pulse_start;
        // Scramble controls after start: they must not affect this run.
        mode = 2'($urandom_range(0, 3)); speed = 4'($urandom_range(0, 15));
        rev = ~rev; end_addr = 20'($urandom_range(0, 15));
        repeat (10) @(posedge clk);
    endtask

    task automatic run_play(input int md, input int n, input int rv, input int ea, input string tag);
        int v, d0;
        d0 = done_cnt;
        setup(md, n, rv, ea);
        for (int k = 0; k < exp_smp.size(); k++) begin
            if (k == exp_smp.size() - 1) check($sformatf("%s early_done", tag), done_cnt, d0);
            tick(64, v);
            check($sformatf("%s smp%0d", tag, k), v, exp_smp[k]);
        end
        repeat (4) @(posedge clk); #1;
        check($sformatf("%s done", tag), done_cnt, d0 + 1);
        check($sformatf("%s busy_end", tag), int'(busy), 0);
        check($sformatf("%s dac_end", tag), int'(dac), 0);
        check($sformatf("%s n_addr", tag), addr_q.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < addr_q.size(); k++)
            check($sformatf("%s addr%0d", tag, k), addr_q[k], exp_addr[k]);
    endtask

    initial begin
        int v, d0, u0, n0, sv;
        rst = 1'b1; start = 0; pause = 0; stop = 0; rev = 0; daclrck = 0;
        mode = 0; speed = 0; end_addr = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk); #1;
        check("rst dac", int'(dac), 0);
        check("rst busy", int'(busy), 0);
        check("rst req", int'(sram_req), 0);
        check("rst done", int'(done), 0);
        check("rst urun", int'(underrun), 0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);

        // Normal playback.
        mem[0] = 100; mem[1] = 200; mem[2] = -300; mem[3] = 400;
        run_play(0, 1, 0, 3, "m0n1");

        // Skip playback forward and reverse.
        for (int i = 0; i < 10; i++) mem[i] = 16'(i * 111 - 500);
        run_play(0, 3, 0, 9, "m0n3fwd");
        run_play(0, 3, 1, 9, "m0n3rev");

        // Linear interpolation, including a full-scale negative swing.
        mem[0] = 0; mem[1] = 100; mem[2] = -100;
        run_play(2, 4, 0, 2, "m2n4");
        mem[0] = 32767; mem[1] = -32768;
        run_play(2, 2, 0, 1, "m2sat");

        // Hold mode with pause after 3 ticks, 5 ticks paused, then resume.
        mem[0] = 10; mem[1] = -20; mem[2] = 30; mem[3] = -40;
        d0 = done_cnt;
        setup(1, 2, 0, 3);
        for (int k = 0; k < 3; k++) begin
            tick(64, v);
            check($sformatf("pause pre%0d", k), v, exp_smp[k]);
        end
        pulse_pause;
        repeat (2) @(posedge clk); #1;
        check("pause dac", int'(dac), 0);
        check("pause busy", int'(busy), 1);
        n0 = addr_q.size();
        for (int k = 0; k < 5; k++) begin
            tick(64, v);
            check($sformatf("paused%0d", k), v, 0);
        end
        check("pause no_fetch", addr_q.size(), n0);
        pulse_pause;
        for (int k = 3; k < exp_smp.size(); k++) begin
            tick(64, v);
            check($sformatf("pause post%0d", k), v, exp_smp[k]);
        end
        repeat (4) @(posedge clk); #1;
        check("pause done", done_cnt, d0 + 1);
        check("pause n_addr", addr_q.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < addr_q.size(); k++)
            check($sformatf("pause addr%0d", k), addr_q[k], exp_addr[k]);

        // Stop during FETCH, data arrives the cycle after.
        lat = 4;
        d0 = done_cnt;
        @(negedge clk) mode = 0; speed = 1; rev = 0; end_addr = 3;
        pulse_start;
        repeat (lat - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        check("stop busy", int'(busy), 0);
        check("stop req", int'(sram_req), 0);
        repeat (6) @(posedge clk); #1;
        check("stop busy_late", int'(busy), 0);
        check("stop dac_late", int'(dac), 0);
        check("stop no_done", done_cnt, d0);
        lat = 2;
        repeat (10) @(posedge clk);

        // Underrun: second tick lands while a slow read is outstanding.
        mem[0] = 1234; mem[1] = -4321; mem[2] = 77; mem[3] = 88;
        u0 = urun_cnt;
        setup(0, 1, 0, 3);
        lat = 40;
        tick(16, v);
        check("urun first", v, 1234);
        tick(16, v);
        check("urun hold", v, 1234);
        check("urun pulse", urun_cnt, u0 + 1);
        lat = 2;
        repeat (40) @(posedge clk);
        tick(64, v);
        check("urun next", v, -4321);
        pulse_stop;
        repeat (10) @(posedge clk);

        // Reset in the middle of playback.
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom) | 16'h0001;
        setup(1, 3, 0, 5);
        tick(64, v);
        check("mrst smp0", v, exp_smp[0]);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("mrst dac", int'(dac), 0);
        check("mrst busy", int'(busy), 0);
        check("mrst req", int'(sram_req), 0);
        check("mrst done", int'(done), 0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);

        // Randomised runs.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            sv = $urandom_range(0, 4);
            run_play($urandom_range(0, 3), sv, $urandom_range(0, 1), $urandom_range(1, 5),
                     $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
